// File: rtl/bram_loader_if.sv
// Host-side job control, byte stream and bram write port of the loader,
// bundled so the loader and its environment share one definition.
interface bram_loader_if #(
    parameter int ABITS = 8,
    parameter int DBITS = 512
);
    // Job control
    logic             start;
    logic [ABITS-1:0] base_addr;
    logic [ABITS:0]   num_words;
    logic             busy;
    logic             done;

    // Byte stream from the host
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;

    // Write port into the operand bram
    logic [ABITS-1:0] wr_addr;
    logic [DBITS-1:0] wr_data;
    logic             wr_en;

    // Host / environment side
    modport master (
        output start, base_addr, num_words, in_valid, in_data,
        input  busy, done, in_ready, wr_addr, wr_data, wr_en
    );

    // Loader side
    modport slave (
        input  start, base_addr, num_words, in_valid, in_data,
        output busy, done, in_ready, wr_addr, wr_data, wr_en
    );
endinterface

// File: rtl/bram_loader.sv
// Packs host bytes little-endian into DBITS-wide words and writes each
// completed word to consecutive bram addresses, then pulses done.
// Every output is a flop or a decode of the state register, so no input
// has a combinational path to an output.
module bram_loader #(
    parameter int ABITS = 8,
    parameter int DBITS = 512
) (
    input  logic         clk,
    input  logic         reset,
    bram_loader_if.slave bus
);
    localparam int NB    = DBITS / 8;
    localparam int CBITS = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CBITS-1:0] LAST_BYTE = CBITS'(NB - 1);
    localparam logic [ABITS:0]   ONE_WORD  = (ABITS + 1)'(1);

    logic [1:0]       state_q,      state_d;
    logic [CBITS-1:0] byte_cnt_q,   byte_cnt_d;
    logic [ABITS:0]   words_left_q, words_left_d;
    logic [ABITS-1:0] cur_addr_q,   cur_addr_d;
    logic [DBITS-1:0] pack_q,       pack_d;
    logic [ABITS-1:0] wr_addr_q,    wr_addr_d;
    logic [DBITS-1:0] wr_data_q,    wr_data_d;

    logic accept;

    // A byte transfers only while filling; in_ready is a pure state decode.
    assign accept       = bus.in_valid && (state_q == S_FILL);

    assign bus.in_ready = (state_q == S_FILL);
    assign bus.wr_en    = (state_q == S_WRITE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    // Next-state and datapath: job setup, byte packing, word commit.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves a latch.
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        words_left_d = words_left_q;
        cur_addr_d   = cur_addr_q;
        pack_d       = pack_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cur_addr_d   = bus.base_addr;
                    words_left_d = bus.num_words;
                    byte_cnt_d   = '0;
                    pack_d       = '0;
                    state_d      = (bus.num_words == '0) ? S_DONE : S_FILL;
                end
            end

            S_FILL: begin
                if (accept) begin
                    for (int i = 0; i < NB; i++) begin
                        if (byte_cnt_q == CBITS'(i)) begin
                            pack_d[8*i +: 8] = bus.in_data;
                        end
                    end
                    if (byte_cnt_q == LAST_BYTE) begin
                        // Word complete: hand it to the write port registers
                        // so wr_data/wr_addr hold steady after the write.
                        byte_cnt_d = '0;
                        wr_data_d  = pack_d;
                        wr_addr_d  = cur_addr_q;
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CBITS'(1);
                    end
                end
            end

            S_WRITE: begin
                cur_addr_d   = cur_addr_q + ABITS'(1);
                words_left_d = words_left_q - ONE_WORD;
                state_d      = (words_left_q == ONE_WORD) ? S_DONE : S_FILL;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            words_left_q <= '0;
            cur_addr_q   <= '0;
            pack_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            words_left_q <= words_left_d;
            cur_addr_q   <= cur_addr_d;
            pack_q       <= pack_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: single word, address wrap, zero length,
// stalls with ignored start pulses, reset mid-job and a full-depth load
// with readback from a behavioural bram.
module tb_bram_loader;
    localparam int ABITS = 8;
    localparam int DBITS = 512;
    localparam int NB    = DBITS / 8;

    logic clk;
    logic reset;

    bram_loader_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

    bram_loader #(.ABITS(ABITS), .DBITS(DBITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Monitor-owned observations of the write port and handshakes.
    logic [DBITS-1:0] mem [256];
    int               wr_cnt    = 0;
    int               done_cnt  = 0;
    int               rdy_cnt   = 0;
    logic [ABITS-1:0] last_addr = '0;
    logic [ABITS-1:0] prev_addr = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural bram plus event counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
            wr_cnt           <= wr_cnt + 1;
            prev_addr        <= last_addr;
            last_addr        <= bus.wr_addr;
        end
        if (bus.done)     done_cnt <= done_cnt + 1;
        if (bus.in_ready) rdy_cnt  <= rdy_cnt + 1;
    end

    task automatic check(input string tag, input logic [DBITS-1:0] got,
                         input logic [DBITS-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte j of word k in a job seeded with seed; 7 is odd so all 256
    // words of a full-depth load differ.
    function automatic logic [7:0] pat(input int k, input int j, input logic [7:0] seed);
        return seed + 8'(7 * k + j);
    endfunction

    function automatic logic [DBITS-1:0] exp_word(input int k, input logic [7:0] seed);
        logic [DBITS-1:0] w;
        w = '0;
        for (int j = 0; j < NB; j++) w[8*j +: 8] = pat(k, j, seed);
        return w;
    endfunction

    // Present one byte after gap idle cycles and hold it until taken.
    task automatic send_byte(input logic [7:0] b, input int gap,
                             output int edges, output bit to);
        int waited;
        edges  = 0;
        to     = 1'b0;
        waited = 0;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
                edges++;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && waited < 100) begin
            @(posedge clk); #1;
            edges++;
            waited++;
        end
        if (!bus.in_ready) begin
            to = 1'b1;
        end else begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // One complete job with per-word write checks and done/busy timing.
    task automatic run_job(input string nm, input logic [7:0] base, input int n,
                           input logic [7:0] seed, input int gap_max, input bit poke);
        int   w0, d0, edges, e, gap;
        bit   to;
        logic [7:0] a;
        w0    = wr_cnt;
        d0    = done_cnt;
        edges = 0;

        bus.base_addr = base;
        bus.num_words = 9'(n);
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({nm, "_busy1"}, bus.busy, 1'b1);
        check({nm, "_rdy1"}, bus.in_ready, n != 0);

        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < NB; j++) begin
                if (poke && j == 10) begin
                    bus.in_valid  = 1'b0;
                    bus.start     = 1'b1;
                    bus.base_addr = 8'hEE;
                    bus.num_words = 9'd7;
                    @(posedge clk); #1;
                    edges++;
                    bus.start = 1'b0;
                end
                gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
                send_byte(pat(k, j, seed), gap, e, to);
                edges += e;
                if (to) begin
                    check({nm, "_rdy_timeout"}, to, 1'b0);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
            bus.in_valid = 1'b0;
            a = base + 8'(k);
            check({nm, "_wr_en"},   bus.wr_en,    1'b1);
            check({nm, "_wr_addr"}, bus.wr_addr,  a);
            check({nm, "_wr_data"}, bus.wr_data,  exp_word(k, seed));
            check({nm, "_rdy_wr"},  bus.in_ready, 1'b0);
            if (poke) begin
                bus.start     = 1'b1;
                bus.base_addr = 8'h3C;
                bus.num_words = 9'd1;
            end
            @(posedge clk); #1;
            edges++;
            bus.start = 1'b0;
            if (k < n - 1) check({nm, "_rdy_next"}, bus.in_ready, 1'b1);
        end

        check({nm, "_done"},     bus.done,  1'b1);
        check({nm, "_wr_en_dn"}, bus.wr_en, 1'b0);
        if (gap_max == 0 && !poke) check({nm, "_lat"}, edges, (NB + 1) * n);
        @(posedge clk); #1;
        check({nm, "_busy0"}, bus.busy, 1'b0);
        check({nm, "_done0"}, bus.done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check({nm, "_nwr"},   wr_cnt - w0,   n);
        check({nm, "_ndone"}, done_cnt - d0, 1);
    endtask

    initial begin
        int   e, w0, d0, r0;
        bit   to;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;

        // Reset state
        #7;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_wr_en",    bus.wr_en,    1'b0);
        check("rst_wr_addr",  bus.wr_addr,  '0);
        check("rst_wr_data",  bus.wr_data,  '0);
        check("rst_busy",     bus.busy,     1'b0);
        check("rst_done",     bus.done,     1'b0);
        #6 reset = 1'b0;
        @(posedge clk); #1;

        // Single word: bytes 0x00..0x3F to address 5
        run_job("single", 8'd5, 1, 8'h00, 0, 1'b0);
        check("single_b0",  mem[5][7:0],     8'h00);
        check("single_b1",  mem[5][15:8],    8'h01);
        check("single_b63", mem[5][511:504], 8'h3F);
        check("single_addr", last_addr,      8'd5);

        // Wrap-around: 255 then 0
        run_job("wrap", 8'hFF, 2, 8'h40, 0, 1'b0);
        check("wrap_a0",  prev_addr, 8'hFF);
        check("wrap_a1",  last_addr, 8'h00);
        check("wrap_m255_lo", mem[255][7:0], 8'h40);
        check("wrap_m0_lo",   mem[0][7:0],   8'h47);
        check("wrap_m0_hi",   mem[0][511:504], 8'h86);

        // Zero length: done right after start, never ready, no write
        r0 = rdy_cnt;
        run_job("zero", 8'd9, 0, 8'h00, 0, 1'b0);
        check("zero_no_ready", rdy_cnt - r0, 0);

        // Random stalls plus start pulses during FILL and WRITE
        run_job("stall", 8'd100, 3, 8'h21, 10, 1'b1);

        // Reset mid-job after 20 bytes of word 0
        w0 = wr_cnt;
        d0 = done_cnt;
        bus.base_addr = 8'd10;
        bus.num_words = 9'd2;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            send_byte(8'(8'hA0 + j), 0, e, to);
            if (to) check("mid_rdy_timeout", to, 1'b0);
        end
        #3 reset = 1'b1;
        #1;
        check("mid_in_ready", bus.in_ready, 1'b0);
        check("mid_wr_en",    bus.wr_en,    1'b0);
        check("mid_wr_addr",  bus.wr_addr,  '0);
        check("mid_wr_data",  bus.wr_data,  '0);
        check("mid_busy",     bus.busy,     1'b0);
        check("mid_done",     bus.done,     1'b0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;
        check("mid_nwr",   wr_cnt - w0,   0);
        check("mid_ndone", done_cnt - d0, 0);
        run_job("after_rst", 8'd20, 1, 8'h55, 0, 1'b0);
        check("after_rst_b0", mem[20][7:0],     8'h55);
        check("after_rst_b63", mem[20][511:504], 8'h94);

        // Full depth with readback
        run_job("full", 8'd0, 256, 8'h03, 0, 1'b0);
        check("full_last_addr", last_addr, 8'hFF);
        for (int a = 0; a < 256; a++) begin
            check("full_rd", mem[a], exp_word(a, 8'h03));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
